// File: rtl/hist_pkg.sv
// Shared histogram types: default widths, drain FSM states and the beat record
// that travels from the RAM read port to the drain output.
package hist_pkg;

  localparam int HIST_BIN_W = 5;
  localparam int HIST_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    QUIESCE,
    ISSUE,
    FLUSH
  } drain_state_t;

  typedef struct packed {
    logic [HIST_BIN_W-1:0] bin;
    logic [HIST_CNT_W-1:0] count;
    logic                  last;
  } drain_beat_t;

endpackage

// File: rtl/hist_drain_fifo.sv
// Small synchronous FIFO of drain beats with a registered head entry;
// simultaneous push and pop are supported, including on a full FIFO.
module hist_drain_fifo
  import hist_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  drain_beat_t   data_i,
  input  logic          pop_i,
  output drain_beat_t   head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  drain_beat_t   mem_q [DEPTH];
  drain_beat_t   head_q, head_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // The head register takes the incoming beat when it would otherwise become
    // empty; a pop with more entries behind it promotes the next stored one.
    if (do_push && ((count_q == '0) || (do_pop && (count_q == CW'(1))))) begin
      head_d = data_i;
    end else if (do_pop && (count_q > CW'(1))) begin
      head_d = mem_q[ptr_inc(rd_ptr_q)];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign head_o  = head_q;
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/hist_drain.sv
// Histogram readout: gates the accumulator, sweeps every bin through the RAM's
// second read port and streams (bin, count) beats, optionally clearing bins.
module hist_drain
  import hist_pkg::*;
#(
  parameter int BIN_W      = HIST_BIN_W,
  parameter int CNT_W      = HIST_CNT_W,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear_en,
  input  logic             acc_idle,
  output logic             hold_acc,
  output logic             busy,
  output logic             done,
  output logic [BIN_W-1:0] rd_addr,
  output logic             rd_en,
  input  logic [CNT_W-1:0] rd_data,
  output logic [BIN_W-1:0] wr_addr,
  output logic [CNT_W-1:0] wr_data,
  output logic             wr_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [BIN_W-1:0] m_bin,
  output logic [CNT_W-1:0] m_count,
  output logic             m_last
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  generate
    if (FIFO_DEPTH < RD_LAT + 1) begin : g_depth_check
      $error("hist_drain: FIFO_DEPTH must be at least RD_LAT+1");
    end
    if (RD_LAT < 1) begin : g_lat_check
      $error("hist_drain: RD_LAT must be at least 1");
    end
    if ((BIN_W != HIST_BIN_W) || (CNT_W != HIST_CNT_W)) begin : g_width_check
      $error("hist_drain: BIN_W/CNT_W must match the hist_pkg beat layout");
    end
  endgenerate

  drain_state_t state_q, state_d;
  logic             clr_q, clr_d;
  logic [BIN_W-1:0] addr_q, addr_d;
  logic [CW-1:0]    inflight_q, inflight_d;

  // Read-return tracker: one valid bit and bin address per cycle of RAM latency.
  logic [RD_LAT-1:0]            ret_vld_q;
  logic [RD_LAT-1:0][BIN_W-1:0] ret_addr_q;
  logic                         ret_vld;
  logic [BIN_W-1:0]             ret_addr;

  drain_beat_t   push_beat, head_beat;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty, pop;
  logic          credit_ok;

  assign ret_vld  = ret_vld_q[RD_LAT-1];
  assign ret_addr = ret_addr_q[RD_LAT-1];

  // Reads already in flight plus beats already buffered must fit in the FIFO,
  // so a return can always be pushed even under full backpressure.
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    addr_d  = addr_q;
    rd_en   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clr_d   = clear_en;
          state_d = QUIESCE;
        end
      end
      QUIESCE: begin
        if (acc_idle) begin
          addr_d  = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (credit_ok) begin
          rd_en  = 1'b1;
          addr_d = addr_q + 1'b1;
          if (addr_q == '1) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if ((inflight_q == '0) && fifo_empty) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    if (rd_en && !ret_vld) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!rd_en && ret_vld) begin
      inflight_d = inflight_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      clr_q      <= 1'b0;
      addr_q     <= '0;
      inflight_q <= '0;
      ret_vld_q  <= '0;
      ret_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_q      <= clr_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      for (int i = RD_LAT - 1; i > 0; i--) begin
        ret_vld_q[i]  <= ret_vld_q[i-1];
        ret_addr_q[i] <= ret_addr_q[i-1];
      end
      ret_vld_q[0]  <= rd_en;
      ret_addr_q[0] <= addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(ret_vld && fifo_full && !pop));
  end

  assign push_beat = '{bin: ret_addr, count: rd_data, last: (ret_addr == '1)};
  assign pop       = m_valid && m_ready;

  hist_drain_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ret_vld),
    .data_i  (push_beat),
    .pop_i   (pop),
    .head_o  (head_beat),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign busy     = (state_q != IDLE);
  assign hold_acc = busy;
  assign rd_addr  = addr_q;

  assign wr_en   = ret_vld && clr_q;
  assign wr_addr = wr_en ? ret_addr : '0;
  assign wr_data = '0;

  assign m_valid = !fifo_empty;
  assign m_bin   = head_beat.bin;
  assign m_count = head_beat.count;
  assign m_last  = m_valid && head_beat.last;

endmodule

// File: tb/tb_hist_drain.sv
// Bench for hist_drain: a latency-accurate RAM model plus a bin-order reference
// of what each drain must emit, under random data and random backpressure.
module tb_hist_drain;

  localparam int BIN_W      = 5;
  localparam int CNT_W      = 32;
  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int NB         = 32;

  logic             clk = 1'b0;
  logic             rst, start, clear_en, acc_idle, m_ready;
  logic             hold_acc, busy, done, rd_en, wr_en, m_valid, m_last;
  logic [BIN_W-1:0] rd_addr, wr_addr, m_bin;
  logic [CNT_W-1:0] rd_data, wr_data, m_count;

  always #5 clk = ~clk;

  hist_drain #(
    .BIN_W      (BIN_W),
    .CNT_W      (CNT_W),
    .RD_LAT     (RD_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .clear_en (clear_en),
    .acc_idle (acc_idle),
    .hold_acc (hold_acc),
    .busy     (busy),
    .done     (done),
    .rd_addr  (rd_addr),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_bin    (m_bin),
    .m_count  (m_count),
    .m_last   (m_last)
  );

  // RAM model: RD_LAT-cycle read pipeline, write port for clears, bulk preload.
  logic [CNT_W-1:0] ram      [NB];
  logic [CNT_W-1:0] init_val [NB];
  logic [CNT_W-1:0] rd_pipe  [RD_LAT];
  logic             load = 1'b0;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < NB; i++) ram[i] <= init_val[i];
    end else if (wr_en) begin
      ram[wr_addr] <= wr_data;
    end
    rd_pipe[0] <= rd_en ? ram[rd_addr] : 'x;
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign rd_data = rd_pipe[RD_LAT-1];

  typedef struct {
    int               bin;
    logic [CNT_W-1:0] cnt;
    bit               last;
  } exp_t;

  exp_t             exp_q[$];
  logic [CNT_W-1:0] ref_mem [NB];
  int               rd_cyc  [NB];

  int errors = 0;
  int checks = 0;
  int rd_cnt, wr_cnt, beat_cnt, done_cnt, last_acc, done_at, cyc_no;
  int rdy_hold, abort_beat;
  bit clr_mode, rdy_random, inject_done_start;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {hold_acc, busy, done, rd_en, wr_en, m_valid, m_last}, 7'b0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_m_bin"}, m_bin, 0);
    chk({tag, "_m_count"}, m_count, 0);
  endtask

  task automatic preload(input bit random_vals);
    for (int i = 0; i < NB; i++) begin
      init_val[i] = random_vals ? CNT_W'($urandom) : CNT_W'(i * 3);
      ref_mem[i]  = init_val[i];
    end
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  // One clock cycle: pick m_ready, check everything visible now, advance.
  task automatic cyc();
    exp_t e;
    if (rdy_hold > 0) begin
      m_ready = 1'b0;
      rdy_hold--;
    end else if (rdy_random) begin
      m_ready = 1'($urandom_range(0, 1));
    end else begin
      m_ready = 1'b1;
    end
    if (rd_en) begin
      chk("rd_addr", rd_addr, rd_cnt);
      chk("credit", (rd_cnt - beat_cnt) < FIFO_DEPTH, 1);
      if (rd_cnt < NB) rd_cyc[rd_cnt] = cyc_no;
      rd_cnt++;
    end
    if (wr_en) begin
      chk("wr_en_allowed", wr_en, clr_mode);
      chk("wr_addr", wr_addr, wr_cnt);
      chk("wr_data", wr_data, 0);
      if (wr_cnt < NB) chk("wr_timing", cyc_no, rd_cyc[wr_cnt] + RD_LAT);
      wr_cnt++;
    end
    if (m_valid && m_ready) begin
      chk("beat_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("m_bin", m_bin, e.bin);
        chk("m_count", m_count, e.cnt);
        chk("m_last", m_last, e.last);
      end
      beat_cnt++;
      last_acc = cyc_no;
      if (abort_beat > 0 && beat_cnt == abort_beat) rst = 1'b1;
    end
    if (done) begin
      done_cnt++;
      done_at = cyc_no;
      if (inject_done_start) start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    cyc_no++;
  endtask

  task automatic run_drain(input bit clr, input int idle_delay, input int abort_at,
                           input bit noise, input bit rand_rdy, input int hold0);
    int  first_rd;
    int  exp_first;
    bit  aborted;
    exp_q.delete();
    for (int b = 0; b < NB; b++) exp_q.push_back('{b, ref_mem[b], (b == NB - 1)});
    rd_cnt = 0; wr_cnt = 0; beat_cnt = 0; done_cnt = 0;
    last_acc = -1; done_at = -1; cyc_no = 0; first_rd = -1; aborted = 1'b0;
    clr_mode = clr; rdy_random = rand_rdy; rdy_hold = hold0;
    abort_beat = abort_at; inject_done_start = noise;
    exp_first = (idle_delay == 0) ? 2 : idle_delay + 2;

    chk("idle_before_start", busy, 0);
    start = 1'b1; clear_en = clr; acc_idle = (idle_delay == 0);
    cyc();
    for (int i = 1; i < 3000 && done_cnt == 0 && !aborted; i++) begin
      clear_en = 1'($urandom_range(0, 1));
      acc_idle = (idle_delay == 0) || (i > idle_delay);
      if (noise && (i == 3 || i == 40)) begin
        start = 1'b1;
        clear_en = !clr;
      end
      if (i == 1) chk("busy_rise", busy, 1);
      if (i <= exp_first) chk("hold_acc", hold_acc, 1);
      if (hold0 > 0 && i == 18) begin
        chk("stall_reads", rd_cnt, FIFO_DEPTH);
        chk("stall_valid", m_valid, 1);
      end
      if (rd_en && first_rd < 0) first_rd = i;
      cyc();
      if (rst) begin
        aborted = 1'b1;
        chk_zero("abort");
        rst = 1'b0;
      end
    end
    if (!aborted) begin
      chk("done_seen", done_cnt, 1);
      chk("first_rd", first_rd, exp_first);
      chk("done_after_last", done_at, last_acc + 1);
      chk("beats", beat_cnt, NB);
      chk("reads", rd_cnt, NB);
      chk("clears", wr_cnt, clr ? NB : 0);
      chk("exp_left", exp_q.size(), 0);
      chk("post_done", {busy, hold_acc, done}, 3'b0);
      for (int k = 0; k < 4; k++) cyc();
      chk("no_restart", busy, 0);
      chk("single_done", done_cnt, 1);
      if (clr) for (int b = 0; b < NB; b++) ref_mem[b] = '0;
      $display("drain clr=%0d idle_delay=%0d rand_ready=%0d: %0d beats, done at cycle %0d",
               clr, idle_delay, rand_rdy, beat_cnt, done_at);
    end else begin
      $display("drain aborted by reset after %0d beats", beat_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear_en = 1'b0; acc_idle = 1'b1; m_ready = 1'b1;
    rdy_hold = 0; rdy_random = 1'b0; abort_beat = 0; inject_done_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    preload(1'b0);
    run_drain(1'b0, 0, 0, 1'b0, 1'b0, 0);   // bin*3 pattern
    run_drain(1'b0, 0, 0, 1'b0, 1'b0, 0);   // unchanged on re-read
    preload(1'b1);
    run_drain(1'b1, 0, 0, 1'b0, 1'b0, 0);   // clearing drain
    run_drain(1'b0, 0, 0, 1'b0, 1'b1, 0);   // everything now zero
    preload(1'b1);
    run_drain(1'b0, 5, 0, 1'b0, 1'b0, 0);   // accumulator slow to go idle
    run_drain(1'b0, 0, 0, 1'b0, 1'b1, 20);  // long stall, then random ready
    run_drain(1'b0, 0, 10, 1'b0, 1'b1, 0);  // reset on the 10th beat
    run_drain(1'b0, 0, 0, 1'b0, 1'b1, 0);   // full drain after abort
    run_drain(1'b1, 0, 0, 1'b1, 1'b1, 0);   // spurious starts ignored
    run_drain(1'b0, 0, 0, 1'b0, 1'b0, 0);   // cleared by previous drain

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
